// File: rtl/readout_feat_pkg.sv
// Shared types and helpers for the readout feature quantizer: FSM states, clog2 and the
// window-sum quantizer (floor shift, mid-scale offset, clamp to the code range).
package readout_feat_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Code is returned in the low feat_bits of the result; feat_bits must not exceed 8.
    function automatic logic [7:0] quantize(input logic signed [63:0] sum,
                                            input int unsigned        shift,
                                            input int unsigned        feat_bits);
        logic signed [63:0] v;
        logic signed [63:0] max_code;
        v        = (sum >>> shift) + (64'sd1 <<< (feat_bits - 1));
        max_code = (64'sd1 <<< feat_bits) - 64'sd1;
        if (v < 64'sd0) begin
            return 8'd0;
        end else if (v > max_code) begin
            return max_code[7:0];
        end
        return v[7:0];
    endfunction

    localparam int unsigned DefSampleW  = 16;
    localparam int unsigned DefNumWin   = 4;
    localparam int unsigned DefWinLen   = 32;
    localparam int unsigned DefFeatBits = 2;

    localparam int unsigned ACC_W  = DefSampleW + clog2(DefWinLen);
    localparam int unsigned FEAT_W = DefNumWin * 2 * DefFeatBits;

endpackage

// File: rtl/readout_window_acc.sv
// One signed boxcar accumulator; on close the final sum (including this beat) is quantized
// into a registered code and the accumulator restarts from zero.
module readout_window_acc
    import readout_feat_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned ACC_W     = 21,
    parameter int unsigned FEAT_BITS = 2,
    parameter int unsigned SHIFT     = 14
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       add_i,
    input  logic                       close_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    output logic [FEAT_BITS-1:0]       code_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic [FEAT_BITS-1:0]    code_q, code_d;
    logic [7:0]              code_full;
    logic                    unused_code_hi;

    always_comb begin
        sample_ext = {{(ACC_W - SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
        // clear makes this beat the first of a window, independent of the old sum
        sum        = (clear_i ? '0 : acc_q) + (add_i ? sample_ext : '0);
        code_full  = quantize({{(64 - ACC_W){sum[ACC_W-1]}}, sum}, SHIFT, FEAT_BITS);

        acc_d  = acc_q;
        code_d = code_q;
        if (clear_i || add_i) begin
            acc_d = sum;
        end
        if (close_i) begin
            acc_d  = '0;
            code_d = code_full[FEAT_BITS-1:0];
        end
    end

    assign unused_code_hi = ^code_full[7:FEAT_BITS];
    assign code_o         = code_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            code_q <= '0;
        end else begin
            acc_q  <= acc_d;
            code_q <= code_d;
        end
    end

endmodule

// File: rtl/readout_feature_quantizer.sv
// Integrates a streamed I/Q readout shot over NUM_WIN boxcar windows and presents the packed
// quantized feature vector to the layer-0 neuron LUTs over a valid/ready handshake.
module readout_feature_quantizer
    import readout_feat_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned NUM_WIN   = 4,
    parameter int unsigned WIN_LEN   = 32,
    parameter int unsigned FEAT_BITS = 2,
    parameter int unsigned SHIFT     = 14
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            s_first,
    input  logic signed [SAMPLE_W-1:0]      s_i,
    input  logic signed [SAMPLE_W-1:0]      s_q,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_WIN*2*FEAT_BITS-1:0]  m_feat,
    output logic [15:0]                     drop_cnt
);

    localparam int unsigned AccW  = SAMPLE_W + clog2(WIN_LEN);
    localparam int unsigned FeatW = NUM_WIN * 2 * FEAT_BITS;
    localparam int unsigned CntW  = clog2(WIN_LEN);
    localparam int unsigned WinW  = (NUM_WIN > 1) ? clog2(NUM_WIN) : 1;

    state_e            state_q, state_d;
    logic              up_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WinW-1:0]   win_q, win_d;
    logic [WinW-1:0]   slot_q, slot_d;
    logic              pend_q, pend_d;
    logic              last_q, last_d;
    logic [FeatW-1:0]  feat_q, feat_d;
    logic [15:0]       drop_q, drop_d;

    logic                 accept;
    logic                 acc_clear, acc_add, acc_close;
    logic [FEAT_BITS-1:0] code_i, code_q;

    // Input is closed while the final window's codes are still being copied into feat_q.
    assign s_ready  = up_q && (state_q != StHold) && !last_q;
    assign accept   = s_valid && s_ready;
    assign m_valid  = (state_q == StHold);
    assign m_feat   = feat_q;
    assign drop_cnt = drop_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        slot_d    = slot_q;
        pend_d    = 1'b0;
        last_d    = 1'b0;
        feat_d    = feat_q;
        drop_d    = drop_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        acc_close = 1'b0;

        // Codes registered by the accumulators on a close land in their slot one cycle later.
        if (pend_q) begin
            feat_d[int'(slot_q)*2*FEAT_BITS +: 2*FEAT_BITS] = {code_q, code_i};
        end
        if (last_q) begin
            state_d = StHold;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && s_first) begin
                    acc_clear = 1'b1;
                    acc_add   = 1'b1;
                    cnt_d     = CntW'(1);
                    win_d     = '0;
                    feat_d    = '0;
                    state_d   = StAccum;
                end else if (accept && (drop_q != 16'hFFFF)) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            StAccum: begin
                if (accept && s_first) begin
                    acc_clear = 1'b1;
                    acc_add   = 1'b1;
                    cnt_d     = CntW'(1);
                    win_d     = '0;
                    feat_d    = '0;
                end else if (accept) begin
                    acc_add = 1'b1;
                    if (cnt_q == CntW'(WIN_LEN - 1)) begin
                        acc_close = 1'b1;
                        cnt_d     = '0;
                        pend_d    = 1'b1;
                        slot_d    = win_q;
                        if (win_q == WinW'(NUM_WIN - 1)) begin
                            last_d = 1'b1;
                            win_d  = '0;
                        end else begin
                            win_d = win_q + WinW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            up_q    <= 1'b0;
            cnt_q   <= '0;
            win_q   <= '0;
            slot_q  <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            feat_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= 1'b1;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            feat_q  <= feat_d;
            drop_q  <= drop_d;
        end
    end

    readout_window_acc #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (AccW),
        .FEAT_BITS(FEAT_BITS),
        .SHIFT    (SHIFT)
    ) u_acc_i (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (acc_clear),
        .add_i   (acc_add),
        .close_i (acc_close),
        .sample_i(s_i),
        .code_o  (code_i)
    );

    readout_window_acc #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (AccW),
        .FEAT_BITS(FEAT_BITS),
        .SHIFT    (SHIFT)
    ) u_acc_q (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (acc_clear),
        .add_i   (acc_add),
        .close_i (acc_close),
        .sample_i(s_q),
        .code_o  (code_q)
    );

endmodule

// File: tb/tb_readout_feature_quantizer.sv
// Directed bench for readout_feature_quantizer with hand-computed feature vectors.
module tb_readout_feature_quantizer;

    logic               clk;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic               s_first;
    logic signed [15:0] s_i;
    logic signed [15:0] s_q;
    logic               m_valid;
    logic               m_ready;
    logic [15:0]        m_feat;
    logic [15:0]        drop_cnt;

    int n_total = 0;
    int n_bad   = 0;

    readout_feature_quantizer dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_first (s_first),
        .s_i     (s_i),
        .s_q     (s_q),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_feat  (m_feat),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic beat(input logic first, input logic [15:0] i, input logic [15:0] q);
        int n;
        s_valid = 1'b1;
        s_first = first;
        s_i     = i;
        s_q     = q;
        n       = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) check("beat_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Per-window sample values packed as {w3, w2, w1, w0}.
    task automatic run_shot(input logic [63:0] iv, input logic [63:0] qv);
        for (int b = 0; b < 128; b++) begin
            beat(b == 0, iv[(b / 32) * 16 +: 16], qv[(b / 32) * 16 +: 16]);
        end
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] exp);
        check({tag, "_lat_pre"}, {31'd0, m_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, "_feat"}, {16'd0, m_feat}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] held;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_first = 1'b0;
        s_i     = '0;
        s_q     = '0;
        m_ready = 1'b1;

        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_feat", {16'd0, m_feat}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        #11 rst = 1'b0;
        #1;
        check("post_rst_not_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, s_ready}, 32'd1);

        // Sums 32768 / 0: I code clamps to 3, Q code mid-scale 2 -> nibble 4'hB per window.
        run_shot({4{16'h0400}}, {4{16'h0000}});
        expect_out("shot_pos", 16'hBBBB);
        @(posedge clk); #1;
        check("shot_pos_done", {31'd0, m_valid}, 32'd0);

        // Sums -16384 / -1048576: I code 1, Q clamps to 0.
        run_shot({4{16'hFE00}}, {4{16'h8000}});
        expect_out("shot_neg", 16'h1111);
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) beat(1'b0, 16'h7FFF, 16'h7FFF);
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("drop5", {16'd0, drop_cnt}, 32'd5);
        run_shot({4{16'h0400}}, {4{16'hFC00}});
        expect_out("after_drop", 16'h3333);
        @(posedge clk); #1;
        check("drop5_kept", {16'd0, drop_cnt}, 32'd5);

        // 40 beats of full-scale junk, then a restart with distinct per-window data:
        // w0 (0,0)->A, w1 (512,-512)->7, w2 (-1024,1024)->C, w3 (256,-1)->6.
        for (int b = 0; b < 40; b++) beat(b == 0, 16'h7FFF, 16'h8000);
        run_shot({16'h0100, 16'hFC00, 16'h0200, 16'h0000},
                 {16'hFFFF, 16'h0400, 16'hFE00, 16'h0000});
        expect_out("restart", 16'h6C7A);
        @(posedge clk); #1;
        check("restart_drop", {16'd0, drop_cnt}, 32'd5);

        // Back-pressure in HOLD with an offered shot start on the input.
        m_ready = 1'b0;
        run_shot({4{16'h0400}}, {4{16'h0000}});
        expect_out("hold", 16'hBBBB);
        held    = m_feat;
        s_valid = 1'b1;
        s_first = 1'b1;
        s_i     = 16'h8000;
        s_q     = 16'h7FFF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_s_ready", {31'd0, s_ready}, 32'd0);
            check("hold_m_valid", {31'd0, m_valid}, 32'd1);
            check("hold_feat", {16'd0, m_feat}, {16'd0, held});
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        s_first = 1'b0;
        @(posedge clk); #1;
        check("hold_release_valid", {31'd0, m_valid}, 32'd0);
        check("hold_release_ready", {31'd0, s_ready}, 32'd1);
        check("hold_drop", {16'd0, drop_cnt}, 32'd5);

        // Reset 70 beats into a shot of full-scale junk.
        for (int b = 0; b < 70; b++) beat(b == 0, 16'h7FFF, 16'h7FFF);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        check("midrst_drop", {16'd0, drop_cnt}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_shot({4{16'hFE00}}, {4{16'h8000}});
        expect_out("after_rst", 16'h1111);
        @(posedge clk); #1;

        // Reset while HOLD is waiting: m_valid must fall without a clock edge.
        m_ready = 1'b0;
        run_shot({4{16'h0400}}, {4{16'h0000}});
        expect_out("hold_rst", 16'hBBBB);
        rst = 1'b1;
        #1;
        check("hold_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("hold_rst_feat", {16'd0, m_feat}, 32'd0);
        #2 rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_rst_ready", {31'd0, s_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
